// File: rtl/reg_alu_bank.sv
// Register bank with a small ALU, a shift-add multiplier and a kernel-mode shadow bank
// that is snapshotted on kernel entry and restored on kernel exit.
module reg_alu_bank #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4,
    parameter int IMM_W = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [$clog2(NREGS)-1:0] i_rd_a_sel,
    input  logic [$clog2(NREGS)-1:0] i_rd_b_sel,
    input  logic                     i_wr_en,
    input  logic [$clog2(NREGS)-1:0] i_wr_sel,
    input  logic [1:0]               i_wr_src,
    input  logic [WIDTH-1:0]         i_memval,
    input  logic [WIDTH-1:0]         i_pc,
    input  logic [IMM_W-1:0]         i_immediate,
    input  logic                     i_alu_en,
    input  logic [3:0]               i_alu_op,
    input  logic [1:0]               i_srcb_sel,
    input  logic                     i_in_kernel,
    output logic [WIDTH-1:0]         o_rd_a_data,
    output logic [WIDTH-1:0]         o_rd_b_data,
    output logic [WIDTH-1:0]         o_alu_out,
    output logic                     o_overflow,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    logic [WIDTH-1:0]   r_regs   [NREGS];
    logic [WIDTH-1:0]   r_shadow [NREGS];
    logic               r_kq;
    logic [WIDTH-1:0]   r_alu_out;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   w_a, w_b, w_imm_sx, w_imm_zx, w_sum, w_diff, w_res, w_wr_data;
    logic [SHW-1:0]     w_shamt;
    logic               w_ovf, w_wr_ok, w_entry, w_exit;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign o_rd_a_data = r_regs[i_rd_a_sel];
    assign o_rd_b_data = r_regs[i_rd_b_sel];
    assign o_alu_out   = r_alu_out;
    assign o_overflow  = r_ovf;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    assign w_a      = r_regs[i_rd_a_sel];
    assign w_imm_sx = {{(WIDTH-IMM_W){i_immediate[IMM_W-1]}}, i_immediate};
    assign w_imm_zx = {{(WIDTH-IMM_W){1'b0}}, i_immediate};

    always_comb begin
        case (i_srcb_sel)
            2'd0:    w_b = r_regs[i_rd_b_sel];
            2'd1:    w_b = w_imm_zx;
            2'd2:    w_b = w_imm_sx;
            default: w_b = w_imm_sx << 2;
        endcase
    end

    assign w_shamt = w_b[SHW-1:0];
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;

    always_comb begin
        w_res = w_b;
        w_ovf = 1'b0;
        case (i_alu_op)
            4'd0: begin
                w_res = w_sum;
                w_ovf = (w_a[M] == w_b[M]) && (w_sum[M] != w_a[M]);
            end
            4'd1: begin
                w_res = w_diff;
                w_ovf = (w_a[M] != w_b[M]) && (w_diff[M] != w_a[M]);
            end
            4'd2:    w_res = w_a & w_b;
            4'd3:    w_res = w_a | w_b;
            4'd4:    w_res = w_a ^ w_b;
            4'd5:    w_res = w_a << w_shamt;
            4'd6:    w_res = w_a >> w_shamt;
            4'd7:    w_res = $signed(w_a) >>> w_shamt;
            4'd8:    w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: w_res = w_b;
        endcase
    end

    always_comb begin
        case (i_wr_src)
            2'd0:    w_wr_data = i_memval;
            2'd1:    w_wr_data = r_alu_out;
            2'd2:    w_wr_data = w_imm_sx;
            default: w_wr_data = i_pc;
        endcase
    end

    // alu_out is stale while multiplying, so writes sourced from it are dropped
    assign w_wr_ok = i_wr_en && !((i_wr_src == 2'd1) && r_busy);
    assign w_entry = i_in_kernel && !r_kq;
    assign w_exit  = !i_in_kernel && r_kq;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i]   <= '0;
                r_shadow[i] <= '0;
            end
            r_kq <= 1'b0;
        end else begin
            r_kq <= i_in_kernel;
            if (w_exit) begin
                for (int i = 0; i < NREGS; i++) r_regs[i] <= r_shadow[i];
            end else if (w_wr_ok) begin
                r_regs[i_wr_sel] <= w_wr_data;
            end
            if (w_entry) begin
                for (int i = 0; i < NREGS; i++) r_shadow[i] <= r_regs[i];
            end
        end
    end

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_alu_out <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH-1)) begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_alu_out <= w_acc_nxt[WIDTH-1:0];
                    r_ovf     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                end
            end else if (i_alu_en) begin
                if (i_alu_op == 4'd10) begin
                    r_busy   <= 1'b1;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, w_a};
                    r_mplier <= w_b;
                end else begin
                    r_alu_out <= w_res;
                    r_ovf     <= w_ovf;
                    r_done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_alu_bank.sv
// Bench for reg_alu_bank: a cycle model of the default build checked every cycle,
// directed scenarios with literal expectations, and a WIDTH=32/NREGS=8 build.
module tb_reg_alu_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  rd_a_sel, rd_b_sel, wr_sel, wr_src, srcb_sel;
    logic        wr_en, alu_en, in_kernel;
    logic [15:0] memval, pc;
    logic [7:0]  imm;
    logic [3:0]  alu_op;
    logic [15:0] rd_a, rd_b, alu_out;
    logic        ovf, busy, done;

    logic [2:0]  h_rd_a_sel, h_rd_b_sel, h_wr_sel;
    logic [1:0]  h_wr_src, h_srcb_sel;
    logic        h_wr_en, h_alu_en;
    logic [31:0] h_memval;
    logic [7:0]  h_imm;
    logic [3:0]  h_alu_op;
    logic [31:0] h_rd_a, h_rd_b, h_alu_out;
    logic        h_ovf, h_busy, h_done;

    reg_alu_bank dut (
        .i_clock(clk), .i_reset(rst), .i_rd_a_sel(rd_a_sel), .i_rd_b_sel(rd_b_sel),
        .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_src(wr_src), .i_memval(memval), .i_pc(pc),
        .i_immediate(imm), .i_alu_en(alu_en), .i_alu_op(alu_op), .i_srcb_sel(srcb_sel),
        .i_in_kernel(in_kernel), .o_rd_a_data(rd_a), .o_rd_b_data(rd_b), .o_alu_out(alu_out),
        .o_overflow(ovf), .o_busy(busy), .o_done(done)
    );

    reg_alu_bank #(.WIDTH(32), .NREGS(8), .IMM_W(8)) dut_w (
        .i_clock(clk), .i_reset(rst), .i_rd_a_sel(h_rd_a_sel), .i_rd_b_sel(h_rd_b_sel),
        .i_wr_en(h_wr_en), .i_wr_sel(h_wr_sel), .i_wr_src(h_wr_src), .i_memval(h_memval),
        .i_pc(h_memval), .i_immediate(h_imm), .i_alu_en(h_alu_en), .i_alu_op(h_alu_op),
        .i_srcb_sel(h_srcb_sel), .i_in_kernel(1'b0), .o_rd_a_data(h_rd_a), .o_rd_b_data(h_rd_b),
        .o_alu_out(h_alu_out), .o_overflow(h_ovf), .o_busy(h_busy), .o_done(h_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default build ----------------
    logic [15:0] m_regs [4] = '{default: 16'h0};
    logic [15:0] m_sh   [4] = '{default: 16'h0};
    logic [15:0] m_alu = 16'h0;
    logic        m_ovf = 1'b0, m_done = 1'b0, m_kq = 1'b0;
    int          m_bcnt = 0;
    logic [31:0] m_prod = 32'h0;
    bit          run_cmp = 1'b0;

    function automatic int s16(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic logic [15:0] model_b(input logic [15:0] rb, input logic [1:0] sel,
                                            input logic [7:0] im);
        int sx;
        sx = (im >= 8'h80) ? int'(im) - 256 : int'(im);
        case (sel)
            2'd0:    return rb;
            2'd1:    return 16'(int'(im));
            2'd2:    return 16'(sx);
            default: return 16'(sx * 4);
        endcase
    endfunction

    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int sa, sb, r, sh;
        sa = s16(a);
        sb = s16(b);
        sh = int'(b) % 16;
        case (op)
            4'd0: begin r = sa + sb; return {(r > 32767 || r < -32768), 16'(r)}; end
            4'd1: begin r = sa - sb; return {(r > 32767 || r < -32768), 16'(r)}; end
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, 16'((int'(a) << sh) & 32'hFFFF)};
            4'd6: return {1'b0, 16'(int'(a) >> sh)};
            4'd7: return {1'b0, 16'(sa >>> sh)};
            4'd8: return {1'b0, (sa < sb) ? 16'd1 : 16'd0};
            default: return {1'b0, b};
        endcase
    endfunction

    task automatic model_step();
        logic [15:0] old [4];
        logic [15:0] a, b, wd;
        logic [16:0] r;
        bit bz;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin m_regs[i] = 0; m_sh[i] = 0; end
            m_alu = 0; m_ovf = 0; m_done = 0; m_kq = 0; m_bcnt = 0;
            return;
        end
        for (int i = 0; i < 4; i++) old[i] = m_regs[i];
        a  = old[rd_a_sel];
        b  = model_b(old[rd_b_sel], srcb_sel, imm);
        bz = (m_bcnt != 0);
        if (wr_en && !(wr_src == 2'd1 && bz)) begin
            case (wr_src)
                2'd0:    wd = memval;
                2'd1:    wd = m_alu;
                2'd2:    wd = model_b(16'h0, 2'd2, imm);
                default: wd = pc;
            endcase
            m_regs[wr_sel] = wd;
        end
        if (in_kernel && !m_kq) for (int i = 0; i < 4; i++) m_sh[i] = old[i];
        if (!in_kernel && m_kq) for (int i = 0; i < 4; i++) m_regs[i] = m_sh[i];
        m_kq = in_kernel;
        m_done = 0;
        if (bz) begin
            m_bcnt--;
            if (m_bcnt == 0) begin
                m_alu = m_prod[15:0]; m_ovf = (m_prod > 32'hFFFF); m_done = 1;
            end
        end else if (alu_en) begin
            if (alu_op == 4'd10) begin
                m_prod = 32'(int'(a)) * 32'(int'(b));
                m_bcnt = 16;
            end else begin
                r = alu_model(alu_op, a, b);
                m_alu = r[15:0]; m_ovf = r[16]; m_done = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (run_cmp && !rst) begin
            chk("m_alu_out", {16'h0, alu_out}, {16'h0, m_alu});
            chk("m_overflow", {31'h0, ovf}, {31'h0, m_ovf});
            chk("m_busy", {31'h0, busy}, {31'h0, (m_bcnt != 0)});
            chk("m_done", {31'h0, done}, {31'h0, m_done});
            chk("m_rd_a", {16'h0, rd_a}, {16'h0, m_regs[rd_a_sel]});
            chk("m_rd_b", {16'h0, rd_b}, {16'h0, m_regs[rd_b_sel]});
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] src, input logic [15:0] val);
        wr_en = 1; wr_sel = sel; wr_src = src; memval = val; pc = val; imm = val[7:0];
        step();
        wr_en = 0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [1:0] asel, input logic [1:0] bsel,
                       input logic [1:0] sb, input logic [7:0] im);
        alu_en = 1; alu_op = op; rd_a_sel = asel; rd_b_sel = bsel; srcb_sel = sb; imm = im;
        step();
        alu_en = 0;
    endtask

    task automatic h_wr(input logic [2:0] sel, input logic [31:0] val);
        h_wr_en = 1; h_wr_sel = sel; h_wr_src = 2'd0; h_memval = val;
        step();
        h_wr_en = 0;
    endtask

    task automatic h_alu(input logic [3:0] op, input logic [2:0] asel, input logic [2:0] bsel,
                         input logic [1:0] sb, input logic [7:0] im);
        h_alu_en = 1; h_alu_op = op; h_rd_a_sel = asel; h_rd_b_sel = bsel;
        h_srcb_sel = sb; h_imm = im;
        step();
        h_alu_en = 0;
    endtask

    logic [15:0] exp4 [4] = '{16'd1, 16'd2, 16'd3, 16'd4};

    initial begin
        rd_a_sel = 0; rd_b_sel = 0; wr_sel = 0; wr_src = 0; srcb_sel = 0;
        wr_en = 0; alu_en = 0; in_kernel = 0; memval = 0; pc = 0; imm = 0; alu_op = 0;
        h_rd_a_sel = 0; h_rd_b_sel = 0; h_wr_sel = 0; h_wr_src = 0; h_srcb_sel = 0;
        h_wr_en = 0; h_alu_en = 0; h_memval = 0; h_imm = 0; h_alu_op = 0;

        repeat (2) step();
        chk("rst_alu_out", {16'h0, alu_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_rd_a", {16'h0, rd_a}, 32'h0);
        rst = 0;
        run_cmp = 1;

        // signed overflow on ADD and SUB
        wr(2'd1, 2'd0, 16'h7FFF);
        alu(4'd0, 2'd1, 2'd0, 2'd1, 8'h01);
        chk("add_out", {16'h0, alu_out}, 32'h8000);
        chk("add_ovf", {31'h0, ovf}, 32'h1);
        chk("add_done", {31'h0, done}, 32'h1);
        step();
        chk("add_done_drop", {31'h0, done}, 32'h0);
        wr(2'd3, 2'd1, 16'h0);
        alu(4'd1, 2'd3, 2'd0, 2'd1, 8'h01);
        chk("sub_out", {16'h0, alu_out}, 32'h7FFF);
        chk("sub_ovf", {31'h0, ovf}, 32'h1);

        // MUL with overflow; alu_en and alu_out-sourced writes ignored mid-op
        wr(2'd0, 2'd0, 16'h0100);
        alu(4'd10, 2'd0, 2'd0, 2'd0, 8'h00);
        chk("mul_busy0", {31'h0, busy}, 32'h1);
        alu_en = 1; alu_op = 4'd0; wr_en = 1; wr_sel = 2'd2; wr_src = 2'd1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("mul_busy", {31'h0, busy}, 32'h1);
            chk("mul_hold", {16'h0, alu_out}, 32'h7FFF);
        end
        alu_en = 0; wr_en = 0;
        step();
        chk("mul_busy_end", {31'h0, busy}, 32'h0);
        chk("mul_out", {16'h0, alu_out}, 32'h0);
        chk("mul_ovf", {31'h0, ovf}, 32'h1);
        chk("mul_done", {31'h0, done}, 32'h1);
        step();
        chk("mul_done_drop", {31'h0, done}, 32'h0);
        rd_b_sel = 2'd2; #1;
        chk("mul_wr_dropped", {16'h0, rd_b}, 32'h0);

        wr(2'd0, 2'd0, 16'h0123);
        alu(4'd10, 2'd0, 2'd0, 2'd1, 8'h45);
        repeat (16) step();
        chk("mul2_out", {16'h0, alu_out}, 32'h4E6F);
        chk("mul2_ovf", {31'h0, ovf}, 32'h0);
        chk("mul2_done", {31'h0, done}, 32'h1);

        // operand B forms
        alu(4'd9, 2'd0, 2'd0, 2'd3, 8'h80);
        chk("passb_sx4", {16'h0, alu_out}, 32'hFE00);
        alu(4'd9, 2'd0, 2'd0, 2'd1, 8'h80);
        chk("passb_zx", {16'h0, alu_out}, 32'h0080);
        alu(4'd9, 2'd0, 2'd0, 2'd2, 8'h80);
        chk("passb_sx", {16'h0, alu_out}, 32'hFF80);

        // write sources imm and pc
        wr(2'd1, 2'd2, 16'h0085);
        wr(2'd2, 2'd3, 16'hBEEF);
        rd_a_sel = 2'd1; rd_b_sel = 2'd2; #1;
        chk("wr_imm", {16'h0, rd_a}, 32'hFF85);
        chk("wr_pc", {16'h0, rd_b}, 32'hBEEF);

        // opcode sweeps, checked by the model
        wr(2'd1, 2'd0, 16'h8000); wr(2'd2, 2'd0, 16'h0001);
        for (int op = 0; op < 16; op++) if (op != 10) alu(4'(op), 2'd1, 2'd2, 2'd0, 8'h0);
        chk("slt_neg", {16'h0, alu_out}, 32'h0001);
        wr(2'd1, 2'd0, 16'h1234); wr(2'd2, 2'd0, 16'hFFF3);
        for (int op = 0; op < 16; op++) if (op != 10) alu(4'(op), 2'd1, 2'd2, 2'd0, 8'h0);
        wr(2'd1, 2'd0, 16'h7000); wr(2'd2, 2'd0, 16'h9000);
        for (int op = 0; op < 9; op++) alu(4'(op), 2'd1, 2'd2, 2'd0, 8'h0);

        // kernel entry/exit
        wr(2'd0, 2'd0, 16'd1); wr(2'd1, 2'd0, 16'd2); wr(2'd2, 2'd0, 16'd3); wr(2'd3, 2'd0, 16'd4);
        in_kernel = 1;
        step();
        wr(2'd0, 2'd0, 16'hAAAA);
        rd_a_sel = 2'd0; #1;
        chk("kern_wr", {16'h0, rd_a}, 32'hAAAA);
        in_kernel = 0;
        wr(2'd2, 2'd0, 16'h5555);
        for (int i = 0; i < 4; i++) begin
            rd_a_sel = 2'(i); #1;
            chk("kern_restore", {16'h0, rd_a}, {16'h0, exp4[i]});
        end
        in_kernel = 1;
        wr(2'd1, 2'd0, 16'h9999);
        rd_a_sel = 2'd1; #1;
        chk("entry_wr", {16'h0, rd_a}, 32'h9999);
        wr(2'd3, 2'd0, 16'h7777);
        in_kernel = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            rd_a_sel = 2'(i); #1;
            chk("entry_restore", {16'h0, rd_a}, {16'h0, exp4[i]});
        end

        // wide build
        h_wr(3'd5, 32'h80000000); h_wr(3'd6, 32'd31);
        h_wr(3'd2, 32'hFFFFFFFF); h_wr(3'd3, 32'd1);
        h_alu(4'd7, 3'd5, 3'd6, 2'd0, 8'h0);
        chk("w_sra", h_alu_out, 32'hFFFFFFFF);
        chk("w_sra_done", {31'h0, h_done}, 32'h1);
        h_alu(4'd6, 3'd5, 3'd6, 2'd0, 8'h0);
        chk("w_srl", h_alu_out, 32'h1);
        h_alu(4'd8, 3'd2, 3'd3, 2'd0, 8'h0);
        chk("w_slt", h_alu_out, 32'h1);
        h_alu(4'd8, 3'd3, 3'd2, 2'd0, 8'h0);
        chk("w_slt_rev", h_alu_out, 32'h0);
        h_alu(4'd5, 3'd3, 3'd6, 2'd0, 8'h0);
        chk("w_sll", h_alu_out, 32'h80000000);
        h_alu(4'd9, 3'd0, 3'd0, 2'd3, 8'h80);
        chk("w_passb_sx4", h_alu_out, 32'hFFFFFE00);

        // reset mid-MUL
        alu(4'd9, 2'd0, 2'd0, 2'd1, 8'h33);
        alu(4'd10, 2'd0, 2'd0, 2'd1, 8'h05);
        repeat (4) step();
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2 rst = 1;
        #1;
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_alu_out", {16'h0, alu_out}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_rd_a", {16'h0, rd_a}, 32'h0);
        step();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst_done", {31'h0, done}, 32'h0);
            chk("post_rst_out", {16'h0, alu_out}, 32'h0);
        end

        run_cmp = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
